sys_ctrl_tx: RTL and testbench

//  Downstream response side of the system controller. Collects register-file read data (8b) and ALU

---
 rtl/sys_ctrl_tx_pkg.sv | 17 +
 rtl/sys_ctrl_tx_pend_slot.sv | 28 ++
 rtl/sys_ctrl_tx.sv | 90 +++++++++
 tb/tb_sys_ctrl_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_tx_pkg.sv
// rtl/sys_ctrl_tx_pkg.sv - shared widths and TX state encoding for the system controller
package sys_ctrl_tx_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ALU_WIDTH  = 2 * DATA_WIDTH;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_SEND_RD     = 2'd1;
  localparam logic [1:0] ST_SEND_ALU_LO = 2'd2;
  localparam logic [1:0] ST_SEND_ALU_HI = 2'd3;

  typedef enum logic [1:0] {
    IDLE        = ST_IDLE,
    SEND_RD     = ST_SEND_RD,
    SEND_ALU_LO = ST_SEND_ALU_LO,
    SEND_ALU_HI = ST_SEND_ALU_HI
  } tx_state_e;
endpackage

// File: rtl/sys_ctrl_tx_pend_slot.sv
// rtl/sys_ctrl_tx_pend_slot.sv - single-entry pending holding register with overflow pulse
module tx_pend_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             ovf_pulse
);
  // A load arriving on the release edge refills the slot instead of being dropped.
  assign ovf_pulse = load & valid & ~clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load && (!valid || clear)) begin
      data  <= din;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/sys_ctrl_tx.sv
// rtl/sys_ctrl_tx.sv - buffers RF read bytes and ALU results and serialises them into the TX FIFO
module sys_ctrl_tx
  import sys_ctrl_tx_pkg::*;
#(
  parameter int DATA_WIDTH = sys_ctrl_tx_pkg::DATA_WIDTH,
  parameter int ALU_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  OUT_Valid,
  input  logic                  FIFO_FULL,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  WR_INC,
  output logic                  busy,
  output logic                  ovf
);
  tx_state_e             state_q, state_n;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_n;
  logic [DATA_WIDTH-1:0] rf_data;
  logic [ALU_WIDTH-1:0]  alu_data;
  logic                  rf_valid, alu_valid, rf_clear, alu_clear;
  logic                  rf_ovf, alu_ovf;

  tx_pend_slot #(.WIDTH(DATA_WIDTH)) u_rf_slot (
    .clk(clk), .rst(rst), .load(RdData_Valid), .clear(rf_clear), .din(RdData),
    .data(rf_data), .valid(rf_valid), .ovf_pulse(rf_ovf)
  );

  tx_pend_slot #(.WIDTH(ALU_WIDTH)) u_alu_slot (
    .clk(clk), .rst(rst), .load(OUT_Valid), .clear(alu_clear), .din(ALU_OUT),
    .data(alu_data), .valid(alu_valid), .ovf_pulse(alu_ovf)
  );

  assign WR_INC  = (state_q != IDLE) & ~FIFO_FULL;
  assign WR_DATA = wr_data_q;
  assign busy    = rf_valid | alu_valid | (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_data_q <= '0;
      ovf       <= 1'b0;
    end else begin
      state_q   <= state_n;
      wr_data_q <= wr_data_n;
      if (rf_ovf || alu_ovf) ovf <= 1'b1;
    end
  end

  // The output byte is latched on entry to each SEND state so it stays stable across stalls.
  always_comb begin
    state_n   = state_q;
    wr_data_n = wr_data_q;
    rf_clear  = 1'b0;
    alu_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (rf_valid) begin
          state_n   = SEND_RD;
          wr_data_n = rf_data;
        end else if (alu_valid) begin
          state_n   = SEND_ALU_LO;
          wr_data_n = alu_data[DATA_WIDTH-1:0];
        end
      end
      SEND_RD: begin
        if (WR_INC) begin
          state_n  = IDLE;
          rf_clear = 1'b1;
        end
      end
      SEND_ALU_LO: begin
        if (WR_INC) begin
          state_n   = SEND_ALU_HI;
          wr_data_n = alu_data[ALU_WIDTH-1:DATA_WIDTH];
        end
      end
      SEND_ALU_HI: begin
        if (WR_INC) begin
          state_n   = IDLE;
          alu_clear = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sys_ctrl_tx.sv
// tb/tb_sys_ctrl_tx.sv - self-checking bench for sys_ctrl_tx with a transaction-level model
module tb_sys_ctrl_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_Valid = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic [7:0]  WR_DATA;
  logic        WR_INC;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  // Model: outstanding transactions per source, ALU half-sent flag, sticky overflow, written log.
  logic [7:0]  rf_q[$];
  logic [15:0] alu_q[$];
  logic        alu_mid = 1'b0;
  logic        m_ovf = 1'b0;
  logic [7:0]  wlog[$];

  sys_ctrl_tx dut (
    .clk(clk), .rst(rst), .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .FIFO_FULL(FIFO_FULL),
    .WR_DATA(WR_DATA), .WR_INC(WR_INC), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic       rf_rel, alu_rel;
    logic [7:0] exp_b;
    if (!rst) begin
      chk("rst_wr_inc", {31'd0, WR_INC}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_wr_data", {24'd0, WR_DATA}, 32'd0);
      rf_q.delete();
      alu_q.delete();
      alu_mid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, (rf_q.size() != 0) || (alu_q.size() != 0)});
      chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
      if (FIFO_FULL) chk("stall_no_wr", {31'd0, WR_INC}, 32'd0);
      rf_rel  = 1'b0;
      alu_rel = 1'b0;
      if (WR_INC) begin
        if (alu_mid) begin
          exp_b   = alu_q[0][15:8];
          alu_rel = 1'b1;
        end else if (rf_q.size() != 0) begin
          exp_b  = rf_q[0];
          rf_rel = 1'b1;
        end else if (alu_q.size() != 0) begin
          exp_b = alu_q[0][7:0];
        end else begin
          exp_b = 8'hxx;
        end
        chk("wr_byte", {24'd0, WR_DATA}, {24'd0, exp_b});
        wlog.push_back(WR_DATA);
        if (rf_rel) void'(rf_q.pop_front());
        else if (alu_rel) begin
          void'(alu_q.pop_front());
          alu_mid = 1'b0;
        end else if (alu_q.size() != 0) alu_mid = 1'b1;
      end
      if (RdData_Valid) begin
        if (rf_q.size() == 0) rf_q.push_back(RdData);
        else m_ovf = 1'b1;
      end
      if (OUT_Valid) begin
        if (alu_q.size() == 0) alu_q.push_back(ALU_OUT);
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input string name, input logic inc, input logic [7:0] d);
    chk({name, "_inc"}, {31'd0, WR_INC}, {31'd0, inc});
    if (inc) chk({name, "_data"}, {24'd0, WR_DATA}, {24'd0, d});
  endtask

  task automatic check_log(input string name, input int n, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] e[3];
    e[0] = b0; e[1] = b1; e[2] = b2;
    chk({name, "_count"}, wlog.size(), n);
    for (int i = 0; i < n && i < wlog.size(); i++)
      chk({name, "_byte"}, {24'd0, wlog[i]}, {24'd0, e[i]});
    wlog.delete();
  endtask

  initial begin
    #1;
    chk("init_wr_inc", {31'd0, WR_INC}, 32'd0);
    chk("init_busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();

    // 1: single RF byte, written two cycles after the strobe
    RdData = 8'h5A; RdData_Valid = 1'b1; tick(); RdData_Valid = 1'b0;
    wr("t1_n", 1'b0, 8'h00);
    tick(); wr("t1_n1", 1'b1, 8'h5A);
    tick(); wr("t1_n2", 1'b0, 8'h00);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_hold", {24'd0, WR_DATA}, 32'h5A);
    check_log("t1", 1, 8'h5A, 8'h00, 8'h00);

    // 2: ALU result, LSB then MSB on consecutive cycles
    ALU_OUT = 16'hBEEF; OUT_Valid = 1'b1; tick(); OUT_Valid = 1'b0;
    tick(); wr("t2_lo", 1'b1, 8'hEF);
    tick(); wr("t2_hi", 1'b1, 8'hBE);
    tick(); wr("t2_end", 1'b0, 8'h00);
    check_log("t2", 2, 8'hEF, 8'hBE, 8'h00);

    // 3: simultaneous strobes, RF first
    RdData = 8'h11; ALU_OUT = 16'h2233; RdData_Valid = 1'b1; OUT_Valid = 1'b1;
    tick(); RdData_Valid = 1'b0; OUT_Valid = 1'b0;
    tick(); wr("t3_rd", 1'b1, 8'h11);
    tick(); tick(); tick(); tick();
    check_log("t3", 3, 8'h11, 8'h33, 8'h22);

    // 4: stall with LO pending for 5 cycles
    ALU_OUT = 16'hA5C3; OUT_Valid = 1'b1; tick(); OUT_Valid = 1'b0;
    FIFO_FULL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); wr("t4_stall", 1'b0, 8'h00);
      chk("t4_stall_data", {24'd0, WR_DATA}, 32'hC3);
    end
    FIFO_FULL = 1'b0; #1;
    wr("t4_lo", 1'b1, 8'hC3);
    tick(); wr("t4_hi", 1'b1, 8'hA5);
    tick(); wr("t4_end", 1'b0, 8'h00);
    check_log("t4", 2, 8'hC3, 8'hA5, 8'h00);

    // 5: second RF strobe while slot full is dropped and flagged
    FIFO_FULL = 1'b1;
    RdData = 8'h01; RdData_Valid = 1'b1; tick();
    RdData = 8'h02; tick(); RdData_Valid = 1'b0;
    tick(); tick();
    chk("t5_ovf", {31'd0, ovf}, 32'd1);
    FIFO_FULL = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_log("t5", 1, 8'h01, 8'h00, 8'h00);

    // 6: reset during SEND_ALU_HI
    ALU_OUT = 16'h1234; OUT_Valid = 1'b1; tick(); OUT_Valid = 1'b0;
    tick(); wr("t6_lo", 1'b1, 8'h34);
    tick(); wr("t6_hi", 1'b1, 8'h12);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_inc", {31'd0, WR_INC}, 32'd0);
    chk("t6_rst_data", {24'd0, WR_DATA}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_ovf", {31'd0, ovf}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_log("t6_quiet", 1, 8'h34, 8'h00, 8'h00);
    RdData = 8'h77; RdData_Valid = 1'b1; tick(); RdData_Valid = 1'b0;
    tick(); tick(); tick();
    check_log("t6_after", 1, 8'h77, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
